// File: rtl/psum_gbf_dbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_gbf_dbuf_pkg
// Purpose  : Shared defaults and encodings for the double-buffered psum GBF
// Revision : 1.0 - initial release
// ============================================================================
package psum_gbf_dbuf_pkg;

  localparam int GBF_DATA_BITWIDTH_DFLT = 512;
  localparam int DEPTH_DFLT             = 32;
  localparam int ADDR_BITWIDTH_DFLT     = 5;

  // Bank select encoding carried on psum_gbf_w_num / drain_bank
  typedef enum logic {
    BUF1 = 1'b0,
    BUF2 = 1'b1
  } bank_sel_e;

  // Drain tracker: PENDING means the drain bank still holds undrained rows
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/psum_gbf_dbuf_ram.sv
`default_nettype none
// ============================================================================
// Module   : gbf_bank_ram
// Purpose  : One GBF bank, DEPTH x GBF_DATA_BITWIDTH, one write port and one
//            registered read port that returns pre-write data on a collision
// Revision : 1.0 - initial release
// ============================================================================
module gbf_bank_ram #(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int DEPTH             = 32,
  parameter int ADDR_BITWIDTH     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [ADDR_BITWIDTH-1:0]     waddr,
  input  logic [GBF_DATA_BITWIDTH-1:0] wdata,
  input  logic                         re,
  input  logic [ADDR_BITWIDTH-1:0]     raddr,
  output logic [GBF_DATA_BITWIDTH-1:0] rdata
);

  logic [GBF_DATA_BITWIDTH-1:0] mem [DEPTH];

  // Storage array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; samples the old row when the same row is written this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/psum_gbf_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : psum_gbf_dbuf
// Purpose  : Double-buffered partial-sum global buffer. One bank takes psum
//            row writes while the other is drained by reads and zero-cleared.
//            Tracks bank swaps, drain completion and protocol violations.
// Revision : 1.0 - initial release
// ============================================================================
module psum_gbf_dbuf
  import psum_gbf_dbuf_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = GBF_DATA_BITWIDTH_DFLT,
  parameter int DEPTH             = DEPTH_DFLT,
  parameter int ADDR_BITWIDTH     = ADDR_BITWIDTH_DFLT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         psum_gbf_w_en,
  input  logic [ADDR_BITWIDTH-1:0]     psum_gbf_w_addr,
  input  logic                         psum_gbf_w_num,
  input  logic [GBF_DATA_BITWIDTH-1:0] psum_gbf_w_data,
  input  logic                         psum_gbf_r_en,
  input  logic [ADDR_BITWIDTH-1:0]     psum_gbf_r_addr,
  input  logic                         psum_gbf_w_en_for_init,
  input  logic [ADDR_BITWIDTH-1:0]     psum_gbf_w_addr_for_init,
  output logic [GBF_DATA_BITWIDTH-1:0] r_data,
  output logic                         r_valid,
  output logic                         drain_bank,
  output logic                         drain_pending,
  output logic                         drain_done,
  output logic                         err_overrun,
  output logic                         err_conflict
);

  localparam logic [ADDR_BITWIDTH-1:0] LAST_ROW = ADDR_BITWIDTH'(DEPTH - 1);

  drain_state_e                 state;
  drain_state_e                 state_next;
  logic                         w_num_q;
  logic                         swap;
  logic                         write_conflict;
  logic                         clear_last;
  logic                         drain_done_next;
  logic                         overrun_set;
  logic                         rd_sel;
  logic [GBF_DATA_BITWIDTH-1:0] bank_rdata [2];

  // A change of the writer's bank number hands the previous bank over to drain
  assign swap           = (psum_gbf_w_num != w_num_q);
  // Writing into a bank that is still awaiting drain would corrupt its psums
  assign write_conflict = psum_gbf_w_en && drain_pending && (psum_gbf_w_num == drain_bank);
  assign clear_last     = psum_gbf_w_en_for_init && (psum_gbf_w_addr_for_init == LAST_ROW);
  assign drain_pending  = (state == PENDING);

  // Drain tracker state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Drain tracker next state: completion is evaluated first, a swap re-arms
  always_comb begin
    state_next      = state;
    drain_done_next = 1'b0;
    overrun_set     = 1'b0;
    case (state)
      IDLE: begin
        if (swap) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (clear_last) begin
          state_next      = IDLE;
          drain_done_next = 1'b1;
        end
        if (swap) begin
          state_next  = PENDING;
          overrun_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bank tracking, drain pulse, sticky error flags and read-side status
  always_ff @(posedge clk) begin
    if (reset) begin
      w_num_q      <= 1'b0;
      drain_bank   <= BUF1;
      drain_done   <= 1'b0;
      err_overrun  <= 1'b0;
      err_conflict <= 1'b0;
      r_valid      <= 1'b0;
      rd_sel       <= BUF1;
    end else begin
      w_num_q    <= psum_gbf_w_num;
      drain_done <= drain_done_next;
      r_valid    <= psum_gbf_r_en;
      if (swap) begin
        drain_bank <= w_num_q;
      end
      if (overrun_set) begin
        err_overrun <= 1'b1;
      end
      if (write_conflict) begin
        err_conflict <= 1'b1;
      end
      if (psum_gbf_r_en) begin
        rd_sel <= drain_bank;
      end
    end
  end

  // Per-bank port muxing: zero-clear of the drain bank or a psum row write
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic                         sel_clear;
    logic                         sel_write;
    logic                         we;
    logic [ADDR_BITWIDTH-1:0]     waddr;
    logic [GBF_DATA_BITWIDTH-1:0] wdata;

    // Clear takes the port when both target this bank
    always_comb begin
      sel_clear = psum_gbf_w_en_for_init && (drain_bank == 1'(b));
      sel_write = psum_gbf_w_en && !write_conflict && (psum_gbf_w_num == 1'(b));
      we        = sel_clear || sel_write;
      waddr     = sel_clear ? psum_gbf_w_addr_for_init : psum_gbf_w_addr;
      wdata     = sel_clear ? '0 : psum_gbf_w_data;
    end

    gbf_bank_ram #(
      .GBF_DATA_BITWIDTH (GBF_DATA_BITWIDTH),
      .DEPTH             (DEPTH),
      .ADDR_BITWIDTH     (ADDR_BITWIDTH)
    ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (psum_gbf_r_en),
      .raddr (psum_gbf_r_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Both banks are read together; the bank that was drain bank at read time is returned
  assign r_data = (rd_sel == BUF2) ? bank_rdata[1] : bank_rdata[0];

endmodule
`default_nettype wire

// File: tb/tb_psum_gbf_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_gbf_dbuf
// Purpose  : Self-checking bench for psum_gbf_dbuf with a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_gbf_dbuf;

  localparam int W = 512;
  localparam int D = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         w_en;
  logic [A-1:0] w_addr;
  logic         w_num;
  logic [W-1:0] w_data;
  logic         r_en;
  logic [A-1:0] r_addr;
  logic         init_en;
  logic [A-1:0] init_addr;
  logic [W-1:0] r_data;
  logic         r_valid;
  logic         drain_bank;
  logic         drain_pending;
  logic         drain_done;
  logic         err_overrun;
  logic         err_conflict;

  int checks = 0;
  int errors = 0;

  psum_gbf_dbuf dut (
    .clk                      (clk),
    .reset                    (reset),
    .psum_gbf_w_en            (w_en),
    .psum_gbf_w_addr          (w_addr),
    .psum_gbf_w_num           (w_num),
    .psum_gbf_w_data          (w_data),
    .psum_gbf_r_en            (r_en),
    .psum_gbf_r_addr          (r_addr),
    .psum_gbf_w_en_for_init   (init_en),
    .psum_gbf_w_addr_for_init (init_addr),
    .r_data                   (r_data),
    .r_valid                  (r_valid),
    .drain_bank               (drain_bank),
    .drain_pending            (drain_pending),
    .drain_done               (drain_done),
    .err_overrun              (err_overrun),
    .err_conflict             (err_conflict)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [W-1:0] m_mem   [2][D];
  bit           m_known [2][D];
  logic [W-1:0] m_rdata;
  bit           m_rd_known;
  bit m_rvalid, m_dbank, m_pend, m_done, m_ovr, m_cfl, m_wnumq;

  task automatic model_step();
    bit swap, cfl, fin, old_pend;
    if (reset) begin
      m_rdata = '0; m_rd_known = 1'b1; m_rvalid = 0; m_dbank = 0; m_pend = 0;
      m_done = 0; m_ovr = 0; m_cfl = 0; m_wnumq = 0;
      return;
    end
    old_pend = m_pend;
    swap = (w_num != m_wnumq);
    cfl  = w_en && m_pend && (w_num == m_dbank);
    fin  = init_en && m_pend && (init_addr == A'(D - 1));
    if (r_en) begin
      m_rdata    = m_mem[m_dbank][r_addr];
      m_rd_known = m_known[m_dbank][r_addr];
    end
    m_rvalid = r_en;
    if (w_en && !cfl) begin
      m_mem[w_num][w_addr]   = w_data;
      m_known[w_num][w_addr] = 1'b1;
    end
    if (init_en) begin
      m_mem[m_dbank][init_addr]   = '0;
      m_known[m_dbank][init_addr] = 1'b1;
    end
    m_done = fin;
    if (fin) m_pend = 0;
    if (swap) begin
      if (old_pend) m_ovr = 1;
      m_pend  = 1;
      m_dbank = m_wnumq;
    end
    if (cfl) m_cfl = 1;
    m_wnumq = w_num;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("drain_bank", W'(drain_bank), W'(m_dbank));
    chk("drain_pending", W'(drain_pending), W'(m_pend));
    chk("drain_done", W'(drain_done), W'(m_done));
    chk("err_overrun", W'(err_overrun), W'(m_ovr));
    chk("err_conflict", W'(err_conflict), W'(m_cfl));
    chk("r_valid", W'(r_valid), W'(m_rvalid));
    if (m_rd_known) chk("r_data", r_data, m_rdata);
  endtask

  // One clock: model and DUT advance on the same edge, outputs sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    w_en = 0; r_en = 0; init_en = 0; reset = 0;
  endtask

  function automatic logic [W-1:0] rnd512();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic         w_num;
    logic         w_en;
    logic [A-1:0] w_addr;
    logic         r_en;
    logic [A-1:0] r_addr;
    logic         init_en;
    logic [A-1:0] init_addr;
    logic         e_bank;
    logic         e_pend;
    logic         e_done;
    logic         e_ovr;
    logic         e_cfl;
    logic         e_rvalid;
    logic         chk_rdata;
    logic [W-1:0] e_rdata;
  } vec_t;

  vec_t vt [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] aa_row;
    logic [W-1:0] dead_row;
    logic [A-1:0] clr_ptr;
    int           done_cnt;

    aa_row   = {64{8'hAA}};
    dead_row = {16{32'hDEADBEEF}};

    // state entering the table: w_num_q=0, drain_bank=1, pending=1, no errors
    vt[0] = '{1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0};
    vt[1] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0};
    vt[2] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0};
    vt[3] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
              {16{32'hC0DE0002}}};
    vt[4] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0};
    vt[5] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0};

    idle_inputs();
    reset = 1; w_num = 0; w_addr = 0; w_data = '0; r_addr = 0; init_addr = 0;
    m_rd_known = 0;

    // reset state
    tick(); tick();
    chk("reset r_data", r_data, '0);
    chk("reset drain_pending", W'(drain_pending), '0);
    idle_inputs();

    // fill bank0 with row*3+1
    for (int i = 0; i < D; i++) begin
      w_en = 1; w_num = 0; w_addr = A'(i); w_data = W'(i * 3 + 1);
      tick();
    end
    idle_inputs();
    w_num = 1;
    tick();
    chk("swap drain_bank", W'(drain_bank), W'(0));
    chk("swap drain_pending", W'(drain_pending), W'(1));

    // drain reads of bank0
    for (int i = 0; i < D; i++) begin
      r_en = 1; r_addr = A'(i);
      tick();
      chk("drain read data", r_data, W'(i * 3 + 1));
      chk("drain read valid", W'(r_valid), W'(1));
    end
    idle_inputs();
    tick();
    chk("r_valid drop", W'(r_valid), W'(0));

    // zero-clear bank0, drain_done exactly once on the last row
    done_cnt = 0;
    for (int i = 0; i < D; i++) begin
      init_en = 1; init_addr = A'(i);
      tick();
      if (drain_done) done_cnt++;
    end
    chk("done on last clear", W'(drain_done), W'(1));
    chk("pending after clear", W'(drain_pending), W'(0));
    idle_inputs();
    tick();
    if (drain_done) done_cnt++;
    chk("drain_done count", W'(done_cnt), W'(1));
    r_en = 1; r_addr = 5'd5;
    tick();
    chk("cleared row5", r_data, '0);
    idle_inputs();

    // fill bank1 with a pattern, row7 = 0xAA..
    for (int i = 0; i < D; i++) begin
      w_en = 1; w_num = 1; w_addr = A'(i);
      w_data = (i == 7) ? aa_row : {16{32'(i) ^ 32'hC0DE0000}};
      tick();
    end
    idle_inputs();
    w_num = 0;
    tick();
    chk("swap2 drain_bank", W'(drain_bank), W'(1));

    // same-cycle read and clear of row 7
    r_en = 1; r_addr = 5'd7; init_en = 1; init_addr = 5'd7;
    tick();
    chk("read-before-clear", r_data, aa_row);
    idle_inputs();
    r_en = 1; r_addr = 5'd7;
    tick();
    chk("row7 after clear", r_data, '0);
    idle_inputs();

    // overrun / conflict / completion table
    for (int v = 0; v < 6; v++) begin
      w_num = vt[v].w_num; w_en = vt[v].w_en; w_addr = vt[v].w_addr; w_data = dead_row;
      r_en = vt[v].r_en; r_addr = vt[v].r_addr;
      init_en = vt[v].init_en; init_addr = vt[v].init_addr;
      tick();
      chk($sformatf("vec%0d drain_bank", v), W'(drain_bank), W'(vt[v].e_bank));
      chk($sformatf("vec%0d drain_pending", v), W'(drain_pending), W'(vt[v].e_pend));
      chk($sformatf("vec%0d drain_done", v), W'(drain_done), W'(vt[v].e_done));
      chk($sformatf("vec%0d err_overrun", v), W'(err_overrun), W'(vt[v].e_ovr));
      chk($sformatf("vec%0d err_conflict", v), W'(err_conflict), W'(vt[v].e_cfl));
      chk($sformatf("vec%0d r_valid", v), W'(r_valid), W'(vt[v].e_rvalid));
      if (vt[v].chk_rdata) chk($sformatf("vec%0d r_data", v), r_data, vt[v].e_rdata);
    end
    idle_inputs();

    // reset in the middle of a drain clear
    w_num = 1;
    tick();
    chk("mid pending", W'(drain_pending), W'(1));
    for (int i = 0; i < 15; i++) begin
      init_en = 1; init_addr = A'(i);
      tick();
    end
    idle_inputs();
    reset = 1; w_num = 0;
    tick();
    reset = 0;
    chk("rst r_data", r_data, '0);
    chk("rst r_valid", W'(r_valid), '0);
    chk("rst drain_bank", W'(drain_bank), '0);
    chk("rst drain_pending", W'(drain_pending), '0);
    chk("rst err_overrun", W'(err_overrun), '0);
    chk("rst err_conflict", W'(err_conflict), '0);
    done_cnt = 0;
    for (int i = 15; i < D; i++) begin
      init_en = 1; init_addr = A'(i);
      tick();
      if (drain_done) done_cnt++;
    end
    idle_inputs();
    tick();
    if (drain_done) done_cnt++;
    chk("no done after reset", W'(done_cnt), W'(0));

    // random fill of bank0, then writes to bank1 interleaved with drain reads of bank0
    for (int i = 0; i < D; i++) begin
      w_en = 1; w_num = 0; w_addr = A'(i); w_data = rnd512();
      tick();
    end
    idle_inputs();
    w_num = 1;
    tick();
    for (int c = 0; c < 64; c++) begin
      w_en = 1; w_addr = A'($urandom); w_data = rnd512();
      r_en = 1; r_addr = A'($urandom);
      tick();
    end
    idle_inputs();
    w_num = 0;
    tick();
    for (int i = 0; i < D; i++) begin
      r_en = 1; r_addr = A'(i);
      tick();
    end
    idle_inputs();

    // randomized traffic against the model
    clr_ptr = '0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) w_num = ~w_num;
      w_en    = !reset && ($urandom_range(0, 1) == 1);
      w_addr  = A'($urandom);
      w_data  = rnd512();
      r_en    = !reset && ($urandom_range(0, 1) == 1);
      r_addr  = A'($urandom);
      init_en = !reset && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        init_addr = A'($urandom);
      end else begin
        init_addr = clr_ptr;
      end
      if (init_en) clr_ptr = clr_ptr + 1'b1;
      if (init_en && w_en && !m_pend && (w_num == m_dbank)) w_en = 0;
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
